// File: rtl/bargraph_update_ctrl.sv
// bargraph_update_ctrl
// Host-side sequencer for the RGB LED bargraph: routes pixel writes into the
// back (non-displayed) buffer, flips the display buffer on commit and waits
// for the scan driver to adopt it, and ramps the global dimming level toward
// the host target.
// Optional feature: define BARGRAPH_AUTO_CLEAR_EN to zero the new back buffer
// (256 writes, one per clock) after every completed flip.
module bargraph_update_ctrl #(
    parameter int RAMP_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [7:0] pix_addr,
    input  logic [7:0] pix_data,
    input  logic       commit,
    output logic       busy,
    output logic       flip_done,
    output logic       commit_ovr,
    input  logic [8:0] level_target,
    output logic       wr,
    output logic [8:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       buffer_select,
    input  logic       buffer_current,
    output logic [8:0] level
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_FLIP_WAIT = 2'd1;
`ifdef BARGRAPH_AUTO_CLEAR_EN
    localparam logic [1:0] S_CLEAR     = 2'd2;
`endif

    localparam logic [15:0] RAMP_LAST = 16'(RAMP_DIV - 1);

    logic [1:0]  state_reg;
    logic [15:0] ramp_cnt_reg;
    logic [8:0]  eff_target;
`ifdef BARGRAPH_AUTO_CLEAR_EN
    logic [7:0]  clear_idx_reg;
`endif

    // Host may only push pixels while idle; busy is simply the complement.
    assign pix_ready  = (state_reg == S_IDLE);
    assign busy       = ~pix_ready;
    assign eff_target = (level_target > 9'd256) ? 9'd256 : level_target;

    // Frame sequencer: pixel writes, commit/flip handshake, optional clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            buffer_select <= 1'b0;
            wr            <= 1'b0;
            wr_addr       <= 9'd0;
            wr_data       <= 8'd0;
            flip_done     <= 1'b0;
            commit_ovr    <= 1'b0;
`ifdef BARGRAPH_AUTO_CLEAR_EN
            clear_idx_reg <= 8'd0;
`endif
        end else begin
            wr         <= 1'b0;
            flip_done  <= 1'b0;
            commit_ovr <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    // The write uses the pre-toggle select, so a pixel taken
                    // together with commit lands in the frame being committed.
                    if (pix_valid) begin
                        wr      <= 1'b1;
                        wr_addr <= {~buffer_select, pix_addr};
                        wr_data <= pix_data;
                    end
                    if (commit) begin
                        buffer_select <= ~buffer_select;
                        state_reg     <= S_FLIP_WAIT;
                    end
                end
                S_FLIP_WAIT: begin
                    // Driver switches only at a frame boundary; no timeout.
                    if (buffer_current == buffer_select) begin
                        flip_done <= 1'b1;
`ifdef BARGRAPH_AUTO_CLEAR_EN
                        clear_idx_reg <= 8'd0;
                        state_reg     <= S_CLEAR;
`else
                        state_reg     <= S_IDLE;
`endif
                    end
                end
`ifdef BARGRAPH_AUTO_CLEAR_EN
                S_CLEAR: begin
                    wr            <= 1'b1;
                    wr_addr       <= {~buffer_select, clear_idx_reg};
                    wr_data       <= 8'd0;
                    clear_idx_reg <= clear_idx_reg + 8'd1;
                    if (clear_idx_reg == 8'd255) begin
                        state_reg <= S_IDLE;
                    end
                end
`endif
                default: state_reg <= S_IDLE;
            endcase
            if (commit && (state_reg != S_IDLE)) begin
                commit_ovr <= 1'b1;
            end
        end
    end

    // Dimming ramp: one step toward the clamped target every RAMP_DIV clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_cnt_reg <= 16'd0;
            level        <= 9'd0;
        end else if (ramp_cnt_reg == RAMP_LAST) begin
            ramp_cnt_reg <= 16'd0;
            if (level < eff_target) begin
                level <= level + 9'd1;
            end else if (level > eff_target) begin
                level <= level - 9'd1;
            end
        end else begin
            ramp_cnt_reg <= ramp_cnt_reg + 16'd1;
        end
    end

endmodule
